// File: rtl/tow_gen.sv
// -----------------------------------------------------------------------------
// tow_gen -- parametrised tug-of-war game core.
//
// Two pushbuttons move a single lit "rope" LED across 2*SIDE+1 positions.
// A left push moves the rope left (pos+1), a right push moves it right (pos-1).
// Every accepted push blanks the display for DARK_CYC cycles before the new
// position (or the win pattern) appears. Pushing past an end wins the round
// and bumps that player's saturating score. new_game restarts the round from
// the centre and keeps the scores.
//
// Optional build macro: TOW_GEN_DEBOUNCE_EN
//   defined   : each button goes through a 2-flop synchroniser plus a
//               DEB_CYC-sample debounce filter before edge detection.
//   undefined : each button is registered once; DEB_CYC is unused.
//
// Ports:
//   clk       in   1        system clock, rising edge
//   rst       in   1        asynchronous reset, active low
//   pbl       in   1        left player button, active high
//   pbr       in   1        right player button, active high
//   new_game  in   1        one-cycle pulse: restart round, keep scores
//   led_out   out  LW       rope display, bit LW-1 is leftmost
//   win_l     out  1        high while the left player has won (WL)
//   win_r     out  1        high while the right player has won (WR)
//   score_l   out  SCORE_W  left rounds won, saturating
//   score_r   out  SCORE_W  right rounds won, saturating
//   busy      out  1        high in INIT and DARK (pushes ignored)
// -----------------------------------------------------------------------------
module tow_gen #(
  parameter  int SIDE     = 3,
  parameter  int DARK_CYC = 4,
  parameter  int SCORE_W  = 4,
  parameter  int DEB_CYC  = 8,
  localparam int LW       = 2*SIDE+1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pbl,
  input  logic               pbr,
  input  logic               new_game,
  output logic [LW-1:0]      led_out,
  output logic               win_l,
  output logic               win_r,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               busy
);

  // Signed position needs room for -SIDE..+SIDE.
  localparam int PW = $clog2(SIDE+1) + 1;
  localparam int CW = $clog2(DARK_CYC+1);

  localparam logic signed [PW-1:0] POS_MAX  = PW'(SIDE);
  localparam logic signed [PW-1:0] POS_MIN  = -POS_MAX;
  localparam logic signed [PW-1:0] POS_ONE  = PW'(1);
  localparam logic signed [PW-1:0] POS_ZERO = '0;
  localparam logic [CW-1:0]        DARK_LAST = CW'(DARK_CYC-1);

  localparam logic [LW-1:0] WL_PAT = {{SIDE{1'b1}}, {(SIDE+1){1'b0}}};
  localparam logic [LW-1:0] WR_PAT = {{(SIDE+1){1'b0}}, {SIDE{1'b1}}};

  // Elaboration-time sanity check of the configuration.
  generate
    if (SIDE < 1 || DARK_CYC < 1 || SCORE_W < 1 || DEB_CYC < 1) begin : g_param_check
      $error("tow_gen: SIDE, DARK_CYC, SCORE_W and DEB_CYC must all be >= 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Button front end. Index 1 = left, index 0 = right.
  // Level and previous-level registers reset to 1 so that a button held
  // through reset never looks like a fresh 0->1 transition.
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] push;

  assign btn_raw = {pbl, pbr};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic lvl_reg;
      logic prev_reg;

`ifdef TOW_GEN_DEBOUNCE_EN
      localparam int DW = $clog2(DEB_CYC+1);
      logic          sync1_reg;
      logic          sync2_reg;
      logic [DW-1:0] deb_cnt_reg;

      // A level change is taken only after DEB_CYC consecutive samples that
      // disagree with the current filtered level; any agreeing sample restarts.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_reg   <= 1'b1;
          sync2_reg   <= 1'b1;
          deb_cnt_reg <= '0;
          lvl_reg     <= 1'b1;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == lvl_reg) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DW'(DEB_CYC-1)) begin
            lvl_reg     <= sync2_reg;
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end
        end
      end
`else
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lvl_reg <= 1'b1;
        end else begin
          lvl_reg <= btn_raw[gi];
        end
      end
`endif

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          prev_reg <= 1'b1;
        end else begin
          prev_reg <= lvl_reg;
        end
      end

      assign push[gi] = lvl_reg & ~prev_reg;
    end
  endgenerate

  logic push_l;
  logic push_r;
  assign push_l = push[1];
  assign push_r = push[0];

  // ---------------------------------------------------------------------------
  // Game FSM. All outputs are registered and updated on the transition that
  // enters the state they belong to.
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_DARK = 3'd1,
    S_SHOW = 3'd2,
    S_WL   = 3'd3,
    S_WR   = 3'd4
  } state_t;

  state_t                 state_reg;
  state_t                 dest_reg;   // where DARK goes when it expires
  logic signed [PW-1:0]   pos_reg;
  logic [CW-1:0]          cnt_reg;

  function automatic logic [LW-1:0] show_pat(input logic signed [PW-1:0] p);
    int idx;
    idx = SIDE + int'(p);
    return LW'(1) << idx;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_INIT;
      dest_reg  <= S_SHOW;
      pos_reg   <= POS_ZERO;
      cnt_reg   <= '0;
      led_out   <= '1;
      win_l     <= 1'b0;
      win_r     <= 1'b0;
      score_l   <= '0;
      score_r   <= '0;
      busy      <= 1'b1;
    end else if (state_reg == S_INIT) begin
      // Leave INIT one cycle after reset release; new_game is ignored here.
      state_reg <= S_DARK;
      dest_reg  <= S_SHOW;
      cnt_reg   <= '0;
      led_out   <= '0;
      busy      <= 1'b1;
    end else if (new_game) begin
      // Restart from the centre; takes priority over any push this cycle.
      state_reg <= S_DARK;
      dest_reg  <= S_SHOW;
      pos_reg   <= POS_ZERO;
      cnt_reg   <= '0;
      led_out   <= '0;
      win_l     <= 1'b0;
      win_r     <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state_reg)
        S_DARK: begin
          if (cnt_reg == DARK_LAST) begin
            state_reg <= dest_reg;
            busy      <= 1'b0;
            case (dest_reg)
              S_WL: begin
                led_out <= WL_PAT;
                win_l   <= 1'b1;
                if (score_l != '1) score_l <= score_l + 1'b1;
              end
              S_WR: begin
                led_out <= WR_PAT;
                win_r   <= 1'b1;
                if (score_r != '1) score_r <= score_r + 1'b1;
              end
              default: led_out <= show_pat(pos_reg);
            endcase
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        S_SHOW: begin
          if (push_l || push_r) begin
            // Any push (including a tie) blanks the display.
            state_reg <= S_DARK;
            dest_reg  <= S_SHOW;
            cnt_reg   <= '0;
            led_out   <= '0;
            busy      <= 1'b1;
            if (push_l && !push_r) begin
              if (pos_reg == POS_MAX) dest_reg <= S_WL;
              else                    pos_reg  <= pos_reg + POS_ONE;
            end else if (push_r && !push_l) begin
              if (pos_reg == POS_MIN) dest_reg <= S_WR;
              else                    pos_reg  <= pos_reg - POS_ONE;
            end
          end
        end

        default: ; // WL / WR hold until new_game or reset
      endcase
    end
  end

endmodule

// File: tb/tb_tow_gen.sv
// -----------------------------------------------------------------------------
// tb_tow_gen -- self-checking bench for tow_gen with default parameters
// (SIDE=3, DARK_CYC=4, SCORE_W=4), debounce feature disabled.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_tow_gen;

  logic       clk;
  logic       rst;
  logic       pbl;
  logic       pbr;
  logic       new_game;
  logic [6:0] led_out;
  logic       win_l;
  logic       win_r;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       busy;

  int checks;
  int passed;

  tow_gen #(
    .SIDE    (3),
    .DARK_CYC(4),
    .SCORE_W (4),
    .DEB_CYC (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pbl     (pbl),
    .pbr     (pbr),
    .new_game(new_game),
    .led_out (led_out),
    .win_l   (win_l),
    .win_r   (win_r),
    .score_l (score_l),
    .score_r (score_r),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired, got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       l;
    logic       r;
    logic       ng;
    logic [6:0] led;
    logic       wl;
    logic       wr;
    logic       bz;
    logic [3:0] sl;
    logic [3:0] sr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic l, input logic r, input logic ng, input logic [6:0] led,
                     input logic wl, input logic wr, input logic bz,
                     input logic [3:0] sl, input logic [3:0] sr);
    vec_t v;
    v.l = l; v.r = r; v.ng = ng; v.led = led;
    v.wl = wl; v.wr = wr; v.bz = bz; v.sl = sl; v.sr = sr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      passed++;
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // Apply inputs, let one rising edge pass, return at the next falling edge.
  task automatic tick(input logic l, input logic r, input logic ng);
    pbl = l; pbr = r; new_game = ng;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One-cycle push followed by the dark phase; returns when the new display
  // is visible.
  task automatic do_push(input logic l, input logic r);
    tick(l, r, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic restart();
    tick(1'b0, 1'b0, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 1'b0);
  endtask

  logic [6:0] grp_from [4];
  logic [6:0] grp_to   [4];

  initial begin
    checks = 0; passed = 0;
    pbl = 1'b0; pbr = 1'b0; new_game = 1'b0;
    rst = 1'b0;

    // ---------------- table: startup, left walk to a win, restart ----------
    add(0,0,0, 7'h00, 0,0,1, 0,0);
    add(0,0,0, 7'h00, 0,0,1, 0,0);
    add(0,0,0, 7'h00, 0,0,1, 0,0);
    add(0,0,0, 7'h00, 0,0,1, 0,0);
    add(0,0,0, 7'h08, 0,0,0, 0,0);
    grp_from = '{7'h08, 7'h10, 7'h20, 7'h40};
    grp_to   = '{7'h10, 7'h20, 7'h40, 7'h70};
    for (int g = 0; g < 4; g++) begin
      add(1,0,0, grp_from[g], 0,0,0, 0,0);   // push registered, not yet acted on
      for (int d = 0; d < 4; d++) add(0,0,0, 7'h00, 0,0,1, 0,0);
      add(0,0,0, grp_to[g], (g == 3), 0, 0, (g == 3) ? 4'd1 : 4'd0, 0);
    end
    add(1,0,0, 7'h70, 1,0,0, 1,0);           // pushes in WL do nothing
    add(0,0,0, 7'h70, 1,0,0, 1,0);
    add(0,0,1, 7'h00, 0,0,1, 1,0);           // new_game from WL, score kept
    add(0,0,0, 7'h00, 0,0,1, 1,0);
    add(0,0,0, 7'h00, 0,0,1, 1,0);
    add(0,0,0, 7'h00, 0,0,1, 1,0);
    add(0,0,0, 7'h08, 0,0,0, 1,0);

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk("reset_led",   32'(led_out), 32'h7F);
    chk("reset_busy",  32'(busy),    32'h1);
    chk("reset_score", 32'({score_l, score_r}), 32'h0);
    chk("reset_win",   32'({win_l, win_r}), 32'h0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].l, tbl[i].r, tbl[i].ng);
      chk($sformatf("row%0d_led", i), 32'(led_out), 32'(tbl[i].led));
      chk($sformatf("row%0d_status", i),
          32'({win_l, win_r, busy, score_l, score_r}),
          32'({tbl[i].wl, tbl[i].wr, tbl[i].bz, tbl[i].sl, tbl[i].sr}));
    end

    // ---------------- walk right to pos=-2 ----------------
    do_push(1'b0, 1'b1);
    do_push(1'b0, 1'b1);
    chk("pos_m2", 32'(led_out), 32'h02);

    // Left push, right push one cycle later: only the left one counts.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    chk("late_right_ignored", 32'(led_out), 32'h04);

    // Both in the same cycle: tie, dark, same position.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("tie_dark", 32'(led_out), 32'h00);
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    chk("tie_same_pos", 32'(led_out), 32'h04);

    // ---------------- held button moves once ----------------
    restart();
    chk("neutral_again", 32'(led_out), 32'h08);
    repeat (20) tick(1'b0, 1'b1, 1'b0);
    chk("held_one_move", 32'(led_out), 32'h04);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    chk("held_release", 32'(led_out), 32'h04);

    // ---------------- push during DARK is dropped, not queued ----------------
    restart();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("dark_push_dropped", 32'(led_out), 32'h10);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    chk("dark_push_not_queued", 32'(led_out), 32'h10);

    // ---------------- new_game beats a simultaneous push ----------------
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    chk("newgame_beats_push", 32'(led_out), 32'h08);

    // ---------------- 16 right wins, score saturates at 15 ----------------
    for (int r = 0; r < 16; r++) begin
      repeat (4) do_push(1'b0, 1'b1);
      chk($sformatf("rwin%0d_led", r), 32'(led_out), 32'h07);
      chk($sformatf("rwin%0d_score", r),
          32'({win_r, score_r, score_l}),
          32'({1'b1, (r < 15) ? 4'(r + 1) : 4'd15, 4'd1}));
      restart();
      if (r == 0) begin
        chk("wr_newgame_led", 32'(led_out), 32'h08);
        chk("wr_newgame_flags", 32'({win_r, score_r}), 32'({1'b0, 4'd1}));
      end
    end
    chk("score_r_saturated", 32'(score_r), 32'd15);

    // ---------------- reset mid-DARK ----------------
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("pre_reset_dark", 32'(led_out), 32'h00);
    #2 rst = 1'b0;
    #1;
    chk("midreset_led",    32'(led_out), 32'h7F);
    chk("midreset_scores", 32'({score_l, score_r}), 32'h0);
    chk("midreset_busy",   32'({busy, win_l, win_r}), 32'h4);
    @(negedge clk);
    rst = 1'b1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
